// File: rtl/sent_rx_pkg.sv
// Shared definitions for the SENT receive CRC arbitration logic:
// channel indices, arbiter states, engine result codes and the grant priority.
package sent_rx_pkg;

  localparam int CH_FAST   = 0;
  localparam int CH_SERIAL = 1;
  localparam int CH_ENH    = 2;
  localparam int NUM_CH    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef logic [1:0] done_code_t;

  localparam done_code_t DONE_NONE = 2'b00;
  localparam done_code_t DONE_PASS = 2'b01;
  localparam done_code_t DONE_FAIL = 2'b10;

  // Fixed priority: fast frames first, then enhanced serial, then short serial.
  function automatic logic [NUM_CH-1:0] priority_select(input logic [NUM_CH-1:0] pending);
    logic [NUM_CH-1:0] sel;
    sel = '0;
    if (pending[CH_FAST]) begin
      sel[CH_FAST] = 1'b1;
    end else if (pending[CH_ENH]) begin
      sel[CH_ENH] = 1'b1;
    end else if (pending[CH_SERIAL]) begin
      sel[CH_SERIAL] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sent_rx_pending_buf.sv
// One-deep holding buffer for a single requester: keeps the latest payload,
// a pending flag, and flags an overwrite of a payload that was never granted.
module sent_rx_pending_buf #(
  parameter int DATA_W = 30
) (
  input  logic              clk_rx,
  input  logic              reset_rx,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  output logic              pending,
  output logic [DATA_W-1:0] data,
  output logic              overrun
);

  // A new request always wins over a grant-clear, so a request arriving in the
  // grant cycle stays pending; overrun is only raised if the old one was not taken.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      pending <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= load & pending & ~clear;
      if (load) begin
        data    <= data_in;
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sent_rx_crc_arbiter.sv
// Shares the single CRC check engine between the fast, short serial and
// enhanced serial requesters, supervising each check with a timeout.
module sent_rx_crc_arbiter
  import sent_rx_pkg::*;
#(
  parameter int DATA_W  = 30,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_rx,
  input  logic              reset_rx,
  input  logic [2:0]        req_i,
  input  logic [DATA_W-1:0] data_fast_i,
  input  logic [DATA_W-1:0] data_serial_i,
  input  logic [DATA_W-1:0] data_enhanced_i,
  output logic [2:0]        enable_crc_check_o,
  output logic [DATA_W-1:0] data_check_crc_o,
  input  logic [1:0]        crc_check_done_i,
  output logic [2:0]        valid_o,
  output logic [2:0]        error_o,
  output logic [2:0]        overrun_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t          state, state_n;
  logic [NUM_CH-1:0]   grant, grant_n;
  logic [NUM_CH-1:0]   sel;
  logic [NUM_CH-1:0]   clear;
  logic [NUM_CH-1:0]   pending;
  logic [DATA_W-1:0]   working, working_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [NUM_CH-1:0]   valid_n, error_n;
  logic [DATA_W-1:0]   chan_data [NUM_CH];
  logic [DATA_W-1:0]   buf_data  [NUM_CH];

  assign chan_data[CH_FAST]   = data_fast_i;
  assign chan_data[CH_SERIAL] = data_serial_i;
  assign chan_data[CH_ENH]    = data_enhanced_i;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_buf
    sent_rx_pending_buf #(
      .DATA_W (DATA_W)
    ) u_buf (
      .clk_rx   (clk_rx),
      .reset_rx (reset_rx),
      .load     (req_i[k]),
      .clear    (clear[k]),
      .data_in  (chan_data[k]),
      .pending  (pending[k]),
      .data     (buf_data[k]),
      .overrun  (overrun_o[k])
    );
  end

  assign sel                = priority_select(pending);
  assign enable_crc_check_o = (state == ST_ISSUE) ? grant : '0;
  assign data_check_crc_o   = working;
  assign busy_o             = (state != ST_IDLE);

  // State register plus the grant, working payload, timeout counter and result pulses.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      state   <= ST_IDLE;
      grant   <= '0;
      working <= '0;
      cnt     <= '0;
      valid_o <= '0;
      error_o <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      working <= working_n;
      cnt     <= cnt_n;
      valid_o <= valid_n;
      error_o <= error_n;
    end
  end

  // Arbitration, issue and result/timeout supervision; engine results outside WAIT are ignored.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    working_n = working;
    cnt_n     = cnt;
    valid_n   = '0;
    error_n   = '0;
    clear     = '0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          grant_n = sel;
          clear   = sel;
          for (int k = 0; k < NUM_CH; k++) begin
            if (sel[k]) begin
              working_n = buf_data[k];
            end
          end
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_n   = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        case (crc_check_done_i)
          DONE_NONE: begin
            if (cnt == CNT_LAST) begin
              error_n = grant;
              state_n = ST_IDLE;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
          DONE_PASS: begin
            valid_n = grant;
            state_n = ST_IDLE;
          end
          DONE_FAIL: begin
            error_n = grant;
            state_n = ST_IDLE;
          end
          default: begin
            error_n = grant;
            state_n = ST_IDLE;
          end
        endcase
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sent_rx_crc_arbiter.sv
// Self-checking bench for sent_rx_crc_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_sent_rx_crc_arbiter;

  localparam int DATA_W  = 30;
  localparam int TIMEOUT = 64;

  logic              clk_rx = 1'b0;
  logic              reset_rx = 1'b1;
  logic [2:0]        req_i = '0;
  logic [DATA_W-1:0] data_fast_i = '0;
  logic [DATA_W-1:0] data_serial_i = '0;
  logic [DATA_W-1:0] data_enhanced_i = '0;
  logic [2:0]        enable_crc_check_o;
  logic [DATA_W-1:0] data_check_crc_o;
  logic [1:0]        crc_check_done_i = '0;
  logic [2:0]        valid_o;
  logic [2:0]        error_o;
  logic [2:0]        overrun_o;
  logic              busy_o;

  always #5 clk_rx = ~clk_rx;

  sent_rx_crc_arbiter #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_rx             (clk_rx),
    .reset_rx           (reset_rx),
    .req_i              (req_i),
    .data_fast_i        (data_fast_i),
    .data_serial_i      (data_serial_i),
    .data_enhanced_i    (data_enhanced_i),
    .enable_crc_check_o (enable_crc_check_o),
    .data_check_crc_o   (data_check_crc_o),
    .crc_check_done_i   (crc_check_done_i),
    .valid_o            (valid_o),
    .error_o            (error_o),
    .overrun_o          (overrun_o),
    .busy_o             (busy_o)
  );

  int     testsRun    = 0;
  int     testsFailed = 0;
  longint cycleNum    = 0;

  // Reference model: pending payloads per channel and the check in flight,
  // tracked by the cycle number at which it was issued.
  bit                mPend [3];
  logic [DATA_W-1:0] mBuf  [3];
  bit                mActive = 1'b0;
  int                mCh     = 0;
  logic [DATA_W-1:0] mData   = '0;
  longint            mIssueAt = 0;

  logic [2:0]        expEnable  = '0;
  logic [2:0]        expValid   = '0;
  logic [2:0]        expError   = '0;
  logic [2:0]        expOverrun = '0;
  logic              expBusy    = 1'b0;
  logic [DATA_W-1:0] expData    = '0;

  // CRC engine stand-in: answers a fixed or random latency after each enable.
  int         engCountdown = -1;
  int         engLatency   = 3;
  logic [1:0] engResult    = 2'b01;
  bit         engRandom    = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cycleNum, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] rndData();
    return DATA_W'($urandom);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mPend[k] = 1'b0;
      mBuf[k]  = '0;
    end
    mActive    = 1'b0;
    mData      = '0;
    expEnable  = '0;
    expValid   = '0;
    expError   = '0;
    expOverrun = '0;
    expBusy    = 1'b0;
    expData    = '0;
  endtask

  task automatic modelAdvance(input logic [2:0] req, input logic [DATA_W-1:0] df,
                              input logic [DATA_W-1:0] ds, input logic [DATA_W-1:0] de,
                              input logic [1:0] done, input bit rst);
    logic [DATA_W-1:0] din [3];
    int                granted;
    int                ch;
    logic [2:0]        nv;
    logic [2:0]        ne;
    logic [2:0]        no;
    din[0]  = df;
    din[1]  = ds;
    din[2]  = de;
    granted = -1;
    nv      = '0;
    ne      = '0;
    no      = '0;
    if (rst) begin
      modelReset();
    end else begin
      if (!mActive) begin
        for (int i = 0; i < 3; i++) begin
          ch = (i == 0) ? 0 : ((i == 1) ? 2 : 1);
          if (granted < 0 && mPend[ch]) granted = ch;
        end
        if (granted >= 0) begin
          mActive  = 1'b1;
          mCh      = granted;
          mData    = mBuf[granted];
          mIssueAt = cycleNum + 1;
        end
      end else if (cycleNum > mIssueAt) begin
        if (done == 2'b01) begin
          nv[mCh] = 1'b1;
          mActive = 1'b0;
        end else if (done != 2'b00) begin
          ne[mCh] = 1'b1;
          mActive = 1'b0;
        end else if (cycleNum - mIssueAt == longint'(TIMEOUT)) begin
          ne[mCh] = 1'b1;
          mActive = 1'b0;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (req[k]) begin
          if (mPend[k] && k != granted) no[k] = 1'b1;
          mBuf[k]  = din[k];
          mPend[k] = 1'b1;
        end else if (k == granted) begin
          mPend[k] = 1'b0;
        end
      end
      expValid   = nv;
      expError   = ne;
      expOverrun = no;
      expBusy    = mActive;
      expEnable  = (mActive && mIssueAt == cycleNum + 1) ? 3'(1 << mCh) : 3'b000;
      expData    = mData;
    end
    cycleNum++;
  endtask

  task automatic compareOutputs();
    checkOutput("enable",  32'(enable_crc_check_o), 32'(expEnable));
    checkOutput("data",    32'(data_check_crc_o),   32'(expData));
    checkOutput("valid",   32'(valid_o),            32'(expValid));
    checkOutput("error",   32'(error_o),            32'(expError));
    checkOutput("overrun", 32'(overrun_o),          32'(expOverrun));
    checkOutput("busy",    32'(busy_o),             32'(expBusy));
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic [DATA_W-1:0] df,
                               input logic [DATA_W-1:0] ds, input logic [DATA_W-1:0] de,
                               input bit rst);
    logic [1:0] done;
    @(negedge clk_rx);
    compareOutputs();
    if (expEnable != 3'b000) begin
      if (engRandom) begin
        if ($urandom_range(0, 3) == 0) engLatency = $urandom_range(TIMEOUT - 2, TIMEOUT + 4);
        else engLatency = $urandom_range(1, 8);
        engResult = 2'($urandom_range(1, 3));
      end
      engCountdown = engLatency;
    end
    done = 2'b00;
    if (engCountdown == 0) begin
      done         = engResult;
      engCountdown = -1;
    end else if (engCountdown > 0) begin
      engCountdown--;
    end else if (engRandom && $urandom_range(0, 15) == 0) begin
      done = 2'($urandom_range(1, 3));
    end
    req_i            = req;
    data_fast_i      = df;
    data_serial_i    = ds;
    data_enhanced_i  = de;
    crc_check_done_i = done;
    reset_rx         = rst;
    modelAdvance(req, df, ds, de, done, rst);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(3'b000, rndData(), rndData(), rndData(), 1'b0);
  endtask

  initial begin
    logic [2:0] r;
    bit         rst;
    modelReset();
    $display("[TB] starting sent_rx_crc_arbiter bench");
    repeat (2) applyStimulus(3'b000, '0, '0, '0, 1'b1);

    // single fast check passing three cycles after enable
    engLatency = 3;
    engResult  = 2'b01;
    applyStimulus(3'b001, 30'h1234567, rndData(), rndData(), 1'b0);
    idle(8);

    // all three channels at once, served fast, enhanced, serial
    applyStimulus(3'b111, 30'h0AAAAAA, 30'h0BBBBBB, 30'h0CCCCCC, 1'b0);
    idle(25);

    // serial payload overwritten while fast check is waiting
    engLatency = 20;
    applyStimulus(3'b001, rndData(), rndData(), rndData(), 1'b0);
    idle(4);
    applyStimulus(3'b010, rndData(), 30'h00000A1, rndData(), 1'b0);
    applyStimulus(3'b010, rndData(), 30'h00000B2, rndData(), 1'b0);
    idle(45);

    // same-channel request in the grant cycle
    engLatency = 2;
    applyStimulus(3'b001, 30'h0111111, rndData(), rndData(), 1'b0);
    applyStimulus(3'b001, 30'h0222222, rndData(), rndData(), 1'b0);
    idle(15);

    // timeout with a late pass that must be ignored
    engLatency = TIMEOUT + 6;
    applyStimulus(3'b001, rndData(), rndData(), rndData(), 1'b0);
    idle(TIMEOUT + 15);

    // result in the very last wait cycle still counts
    engLatency = TIMEOUT;
    applyStimulus(3'b100, rndData(), rndData(), rndData(), 1'b0);
    idle(TIMEOUT + 8);

    // result one cycle too late: timeout, then ignored
    engLatency = TIMEOUT + 1;
    applyStimulus(3'b010, rndData(), rndData(), rndData(), 1'b0);
    idle(TIMEOUT + 8);

    // engine failure, then reset during the next wait
    engLatency = 2;
    engResult  = 2'b10;
    applyStimulus(3'b001, rndData(), rndData(), rndData(), 1'b0);
    idle(8);
    engLatency = 10;
    engResult  = 2'b01;
    applyStimulus(3'b010, rndData(), rndData(), rndData(), 1'b0);
    idle(5);
    applyStimulus(3'b000, rndData(), rndData(), rndData(), 1'b1);
    idle(15);

    // randomized traffic
    engRandom = 1'b1;
    repeat (4000) begin
      for (int k = 0; k < 3; k++) r[k] = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 599) == 0);
      applyStimulus(r, rndData(), rndData(), rndData(), rst);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
